// File: rtl/axis_downsizer_pkg.sv
// Shared types and helpers for the AXI-Stream width down-converter.
// Optional TKEEP support is enabled with AXIS_DOWNSIZER_TKEEP_EN.
package axis_downsizer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Maps emission order i to the physical subword position in the wide beat.
    function automatic int unsigned sub_sel(input int unsigned i, input int unsigned ratio,
                                            input bit msw_first);
        return msw_first ? (ratio - 1 - i) : i;
    endfunction

endpackage

// File: rtl/axis_downsizer_if.sv
// AXI-Stream bus bundle for axis_downsizer; TKEEP exists only with AXIS_DOWNSIZER_TKEEP_EN.
interface axis_downsizer_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned USER_WIDTH = 32
);
    import axis_downsizer_pkg::*;

    logic                  TVALID;
    logic                  TREADY;
    logic [WIDTH-1:0]      TDATA;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
    logic [WIDTH/8-1:0]    TKEEP;
`endif
    logic                  TLAST;
    logic [USER_WIDTH-1:0] TUSER;

    modport master (
        output TVALID, TDATA,
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        output TKEEP,
`endif
        output TLAST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA,
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        input  TKEEP,
`endif
        input  TLAST, TUSER,
        output TREADY
    );

endinterface

// File: rtl/axis_downsizer_lastsel.sv
// Priority encoder: emission index of the last subword carrying any keep bit (0 if none).
module axis_downsizer_lastsel
    import axis_downsizer_pkg::*;
#(
    parameter int unsigned RATIO     = 2,
    parameter int unsigned KW        = 4,
    parameter int unsigned IW        = 1,
    parameter int unsigned MSW_FIRST = 0
) (
    input  logic [RATIO*KW-1:0] keep,
    output logic [IW-1:0]       lidx
);

    logic [RATIO-1:0] any;

    for (genvar g = 0; g < RATIO; g++) begin : g_any
        assign any[g] = |keep[sub_sel(g, RATIO, MSW_FIRST != 0)*KW +: KW];
    end

    always_comb begin
        lidx = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (any[i]) lidx = IW'(i);
        end
    end

endmodule

// File: rtl/axis_downsizer.sv
// AXI-Stream S_WIDTH -> M_WIDTH down-converter with first-beat TUSER capture on SRCDEST.
// Define AXIS_DOWNSIZER_TKEEP_EN to forward TKEEP and trim trailing empty subwords on TLAST.
module axis_downsizer
    import axis_downsizer_pkg::*;
#(
    parameter int unsigned S_WIDTH    = 64,
    parameter int unsigned M_WIDTH    = 32,
    parameter int unsigned USER_WIDTH = 32,
    parameter int unsigned MSW_FIRST  = 0
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESETN,
    axis_downsizer_if.slave       s_axis,
    axis_downsizer_if.master      m_axis,
    output logic [USER_WIDTH-1:0] SRCDEST
);

    localparam int unsigned RATIO = S_WIDTH / M_WIDTH;
    localparam int unsigned IW    = clog2(RATIO);
    localparam int unsigned KW    = M_WIDTH / 8;

    state_t              state;
    logic [M_WIDTH-1:0]  s_sub   [RATIO];
    logic [M_WIDTH-1:0]  buf_sub [RATIO];
    logic                buf_last;
    logic [IW-1:0]       idx, lidx, idx_nxt, lidx_new;
    logic                first;
    logic [M_WIDTH-1:0]  m_data;
    logic                m_last;
    logic                at_last, s_ready, s_xfr, m_xfr;

    // Incoming beat is reordered into emission order once, so idx addresses it directly.
    for (genvar g = 0; g < RATIO; g++) begin : g_sub
        assign s_sub[g] = s_axis.TDATA[sub_sel(g, RATIO, MSW_FIRST != 0)*M_WIDTH +: M_WIDTH];
    end

`ifdef AXIS_DOWNSIZER_TKEEP_EN
    logic [KW-1:0] s_ksub   [RATIO];
    logic [KW-1:0] buf_ksub [RATIO];
    logic [KW-1:0] m_keep;
    logic [IW-1:0] ls_idx;

    for (genvar g = 0; g < RATIO; g++) begin : g_ksub
        assign s_ksub[g] = s_axis.TKEEP[sub_sel(g, RATIO, MSW_FIRST != 0)*KW +: KW];
    end

    axis_downsizer_lastsel #(
        .RATIO     (RATIO),
        .KW        (KW),
        .IW        (IW),
        .MSW_FIRST (MSW_FIRST)
    ) u_lastsel (
        .keep (s_axis.TKEEP),
        .lidx (ls_idx)
    );

    assign lidx_new      = s_axis.TLAST ? ls_idx : IW'(RATIO - 1);
    assign m_axis.TKEEP  = m_keep;
`else
    assign lidx_new      = IW'(RATIO - 1);
`endif

    assign idx_nxt = idx + IW'(1);
    assign at_last = (idx == lidx);
    // Ready looks through to the master only on the final subword so reloads cost no bubble.
    assign s_ready = (state == EMPTY) | (m_axis.TREADY & at_last);
    assign s_xfr   = s_axis.TVALID & s_ready;
    assign m_xfr   = (state == FULL) & m_axis.TREADY;

    assign s_axis.TREADY = s_ready;
    assign m_axis.TVALID = (state == FULL);
    assign m_axis.TDATA  = m_data;
    assign m_axis.TLAST  = m_last;
    assign m_axis.TUSER  = SRCDEST;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state    <= EMPTY;
            for (int unsigned i = 0; i < RATIO; i++) buf_sub[i] <= '0;
            buf_last <= 1'b0;
            idx      <= '0;
            lidx     <= '0;
            first    <= 1'b1;
            SRCDEST  <= '0;
            m_data   <= '0;
            m_last   <= 1'b0;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
            for (int unsigned i = 0; i < RATIO; i++) buf_ksub[i] <= '0;
            m_keep   <= '0;
`endif
        end else if (s_xfr) begin
            state    <= FULL;
            buf_sub  <= s_sub;
            buf_last <= s_axis.TLAST;
            idx      <= '0;
            lidx     <= lidx_new;
            m_data   <= s_sub[0];
            m_last   <= s_axis.TLAST & (lidx_new == '0);
            first    <= s_axis.TLAST;
            if (first) SRCDEST <= s_axis.TUSER;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
            buf_ksub <= s_ksub;
            m_keep   <= s_ksub[0];
`endif
        end else if (m_xfr) begin
            if (!at_last) begin
                idx    <= idx_nxt;
                m_data <= buf_sub[idx_nxt];
                m_last <= buf_last & (idx_nxt == lidx);
`ifdef AXIS_DOWNSIZER_TKEEP_EN
                m_keep <= buf_ksub[idx_nxt];
`endif
            end else begin
                state  <= EMPTY;
                m_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed self-checking bench for axis_downsizer (64->32 and 128->32 instances).
module tb_axis_downsizer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    axis_downsizer_if #(.WIDTH(64),  .USER_WIDTH(32)) s64();
    axis_downsizer_if #(.WIDTH(32),  .USER_WIDTH(32)) m64();
    axis_downsizer_if #(.WIDTH(128), .USER_WIDTH(32)) s128();
    axis_downsizer_if #(.WIDTH(32),  .USER_WIDTH(32)) m128();

    logic [31:0] src64, src128;

    axis_downsizer #(.S_WIDTH(64), .M_WIDTH(32), .USER_WIDTH(32), .MSW_FIRST(0)) dut64 (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .s_axis(s64), .m_axis(m64), .SRCDEST(src64));

    axis_downsizer #(.S_WIDTH(128), .M_WIDTH(32), .USER_WIDTH(32), .MSW_FIRST(0)) dut128 (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .s_axis(s128), .m_axis(m128), .SRCDEST(src128));

    logic r64_fix = 1'b1;
    logic rnd_en  = 1'b0;
    logic rnd_bit = 1'b1;
    assign m64.TREADY  = rnd_en ? rnd_bit : r64_fix;
    assign m128.TREADY = 1'b1;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    logic [3:0] kp64, kp128;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
    assign kp64  = m64.TKEEP;
    assign kp128 = m128.TKEEP;
`else
    assign kp64  = '0;
    assign kp128 = '0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [37:0] obs;
        logic [37:0] exp;
    } stall_t;

    beat_t  q64[$];
    beat_t  q128[$];
    stall_t sq[$];

    int          cyc = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [3:0]  pk = '0;
    logic [31:0] pd = '0;

    // Output monitor: collects accepted beats and records every stalled cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr)
                sq.push_back('{{m64.TVALID, m64.TLAST, kp64, m64.TDATA}, {1'b1, pl, pk, pd}});
            if (m64.TVALID && m64.TREADY)
                q64.push_back('{m64.TDATA, kp64, m64.TLAST, cyc});
            if (m128.TVALID && m128.TREADY)
                q128.push_back('{m128.TDATA, kp128, m128.TLAST, cyc});
            pv <= m64.TVALID;
            pr <= m64.TREADY;
            pd <= m64.TDATA;
            pl <= m64.TLAST;
            pk <= kp64;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send64(input logic [63:0] d, input logic [7:0] k, input logic l,
                          input logic [31:0] u);
        int n = 0;
        s64.TVALID = 1'b1;
        s64.TDATA  = d;
        s64.TLAST  = l;
        s64.TUSER  = u;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        s64.TKEEP  = k;
`endif
        while (!s64.TREADY && n < 200) begin
            tick();
            n++;
        end
        chk("s64 accept", 64'(n < 200), 64'd1);
        tick();
    endtask

    task automatic send128(input logic [127:0] d, input logic l);
        int n = 0;
        s128.TVALID = 1'b1;
        s128.TDATA  = d;
        s128.TLAST  = l;
        s128.TUSER  = 32'h0;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        s128.TKEEP  = '1;
`endif
        while (!s128.TREADY && n < 200) begin
            tick();
            n++;
        end
        chk("s128 accept", 64'(n < 200), 64'd1);
        tick();
    endtask

    int r64  = 0;
    int r128 = 0;

    task automatic wait64(input int n);
        int c = 0;
        while (q64.size() < n && c < 300) begin
            tick();
            c++;
        end
        chk("q64 beats", 64'(q64.size() >= n), 64'd1);
    endtask

    task automatic expect64(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic l, input bit chk_data);
        if (r64 < q64.size()) begin
            if (chk_data) chk({tag, " data"}, 64'(q64[r64].data), 64'(d));
            chk({tag, " last"}, 64'(q64[r64].last), 64'(l));
`ifdef AXIS_DOWNSIZER_TKEEP_EN
            chk({tag, " keep"}, 64'(q64[r64].keep), 64'(k));
`endif
        end else begin
            chk({tag, " present"}, 64'(q64.size()), 64'(r64 + 1));
        end
        r64++;
    endtask

    initial begin
        int b;
        s64.TVALID  = 1'b0; s64.TDATA  = '0; s64.TLAST  = 1'b0; s64.TUSER  = '0;
        s128.TVALID = 1'b0; s128.TDATA = '0; s128.TLAST = 1'b0; s128.TUSER = '0;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        s64.TKEEP  = '1;
        s128.TKEEP = '1;
`endif
        repeat (3) @(posedge clk);
        #2;
        chk("rst m_tvalid", 64'(m64.TVALID), 64'd0);
        chk("rst m_tlast",  64'(m64.TLAST),  64'd0);
        chk("rst m_tdata",  64'(m64.TDATA),  64'd0);
        chk("rst srcdest",  64'(src64),      64'd0);
        chk("rst s_tready", 64'(s64.TREADY), 64'd1);
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        chk("rst m_tkeep",  64'(m64.TKEEP),  64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // single beat, cycle-exact
        s64.TVALID = 1'b1; s64.TDATA = 64'h1111_2222_3333_4444; s64.TLAST = 1'b1;
        s64.TUSER  = 32'hA5A5_0001;
        chk("t1 s_tready empty", 64'(s64.TREADY), 64'd1);
        tick();
        s64.TVALID = 1'b0;
        chk("t1 b0 valid",   64'(m64.TVALID), 64'd1);
        chk("t1 b0 data",    64'(m64.TDATA),  64'h3333_4444);
        chk("t1 b0 last",    64'(m64.TLAST),  64'd0);
        chk("t1 b0 s_ready", 64'(s64.TREADY), 64'd0);
        chk("t1 srcdest",    64'(src64),      64'hA5A5_0001);
        tick();
        chk("t1 b1 valid",   64'(m64.TVALID), 64'd1);
        chk("t1 b1 data",    64'(m64.TDATA),  64'h1111_2222);
        chk("t1 b1 last",    64'(m64.TLAST),  64'd1);
        chk("t1 b1 s_ready", 64'(s64.TREADY), 64'd1);
        tick();
        chk("t1 idle valid",   64'(m64.TVALID), 64'd0);
        chk("t1 idle s_ready", 64'(s64.TREADY), 64'd1);
        r64 = q64.size();

        // two-beat packet, SRCDEST capture, no gap across beats
        chk("t2 srcdest hold", 64'(src64), 64'hA5A5_0001);
        b = r64;
        send64(64'h0102_0304_0506_0708, 8'hFF, 1'b0, 32'h5A5A_0002);
        chk("t2 srcdest first", 64'(src64), 64'h5A5A_0002);
        send64(64'h1112_1314_1516_1718, 8'hFF, 1'b1, 32'hFFFF_0003);
        s64.TVALID = 1'b0;
        chk("t2 srcdest mid", 64'(src64), 64'h5A5A_0002);
        wait64(r64 + 4);
        expect64("t2 b0", 32'h0506_0708, 4'hF, 1'b0, 1'b1);
        expect64("t2 b1", 32'h0102_0304, 4'hF, 1'b0, 1'b1);
        expect64("t2 b2", 32'h1516_1718, 4'hF, 1'b0, 1'b1);
        expect64("t2 b3", 32'h1112_1314, 4'hF, 1'b1, 1'b1);
        if (q64.size() >= b + 4) chk("t2 gap", 64'(q64[b+3].cyc - q64[b].cyc), 64'd3);

        // random master back-pressure
        rnd_en = 1'b1;
        send64(64'hAAAA_0001_BBBB_0002, 8'hFF, 1'b0, 32'h0000_0011);
        send64(64'hCCCC_0003_DDDD_0004, 8'hFF, 1'b0, 32'h0000_0022);
        send64(64'hEEEE_0005_FFFF_0006, 8'hFF, 1'b1, 32'h0000_0033);
        s64.TVALID = 1'b0;
        wait64(r64 + 6);
        rnd_en = 1'b0;
        tick();
        chk("t3 srcdest", 64'(src64), 64'h0000_0011);
        expect64("t3 b0", 32'hBBBB_0002, 4'hF, 1'b0, 1'b1);
        expect64("t3 b1", 32'hAAAA_0001, 4'hF, 1'b0, 1'b1);
        expect64("t3 b2", 32'hDDDD_0004, 4'hF, 1'b0, 1'b1);
        expect64("t3 b3", 32'hCCCC_0003, 4'hF, 1'b0, 1'b1);
        expect64("t3 b4", 32'hFFFF_0006, 4'hF, 1'b0, 1'b1);
        expect64("t3 b5", 32'hEEEE_0005, 4'hF, 1'b1, 1'b1);

        // reset while holding the second subword
        r64_fix = 1'b0;
        send64(64'h2222_BBBB_1111_AAAA, 8'hFF, 1'b1, 32'h0BAD_0001);
        s64.TVALID = 1'b0;
        chk("t4 hold b0", 64'(m64.TDATA), 64'h1111_AAAA);
        r64_fix = 1'b1;
        tick();
        r64_fix = 1'b0;
        chk("t4 hold b1 data", 64'(m64.TDATA), 64'h2222_BBBB);
        chk("t4 hold b1 last", 64'(m64.TLAST), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4 rst valid",   64'(m64.TVALID), 64'd0);
        chk("t4 rst last",    64'(m64.TLAST),  64'd0);
        chk("t4 rst data",    64'(m64.TDATA),  64'd0);
        chk("t4 rst srcdest", 64'(src64),      64'd0);
        chk("t4 rst s_ready", 64'(s64.TREADY), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        r64 = q64.size();
        r64_fix = 1'b1;
        chk("t4 srcdest pre", 64'(src64), 64'd0);
        send64(64'h4444_DDDD_3333_CCCC, 8'hFF, 1'b1, 32'hC0DE_0004);
        s64.TVALID = 1'b0;
        chk("t4 srcdest post", 64'(src64), 64'hC0DE_0004);
        wait64(r64 + 2);
        expect64("t4 b0", 32'h3333_CCCC, 4'hF, 1'b0, 1'b1);
        expect64("t4 b1", 32'h4444_DDDD, 4'hF, 1'b1, 1'b1);

        // 128->32, four back-to-back beats
        r128 = q128.size();
        send128(128'h0000_0004_0000_0003_0000_0002_0000_0001, 1'b0);
        send128(128'h0000_0008_0000_0007_0000_0006_0000_0005, 1'b0);
        send128(128'h0000_000C_0000_000B_0000_000A_0000_0009, 1'b0);
        send128(128'h0000_0010_0000_000F_0000_000E_0000_000D, 1'b1);
        s128.TVALID = 1'b0;
        begin
            int c = 0;
            while (q128.size() < r128 + 16 && c < 300) begin
                tick();
                c++;
            end
        end
        chk("q128 beats", 64'(q128.size() >= r128 + 16), 64'd1);
        if (q128.size() >= r128 + 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("t5 b%0d data", i), 64'(q128[r128+i].data), 64'(i + 1));
                chk($sformatf("t5 b%0d last", i), 64'(q128[r128+i].last), 64'(i == 15));
                chk($sformatf("t5 b%0d gap", i),
                    64'(q128[r128+i].cyc - q128[r128].cyc), 64'(i));
            end
        end

`ifdef AXIS_DOWNSIZER_TKEEP_EN
        // keep trimming on TLAST beats
        send64(64'h0102_0304_0506_0708, 8'hFF, 1'b0, 32'h0000_0066);
        send64(64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1, 32'h0000_0066);
        send64(64'hCCCC_CCCC_DDDD_DDDD, 8'h00, 1'b1, 32'h0000_0077);
        s64.TVALID = 1'b0;
        wait64(r64 + 4);
        expect64("t6 b0", 32'h0506_0708, 4'hF, 1'b0, 1'b1);
        expect64("t6 b1", 32'h0102_0304, 4'hF, 1'b0, 1'b1);
        expect64("t6 b2", 32'hBBBB_BBBB, 4'hF, 1'b1, 1'b1);
        expect64("t6 b3", 32'h0000_0000, 4'h0, 1'b1, 1'b0);
        tick();
        chk("t6 drained", 64'(q64.size()), 64'(r64));
`endif

        chk("stall seen", 64'(sq.size() > 0), 64'd1);
        foreach (sq[i]) chk($sformatf("stall %0d", i), 64'(sq[i].obs), 64'(sq[i].exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_downsizer.md
# axis_downsizer

Parametrised AXI-Stream width down-converter that splits each S_WIDTH-bit slave beat into RATIO = S_WIDTH/M_WIDTH master beats. It runs at full throughput with no bubbles between packets, and latches the packet's first-beat TUSER onto SRCDEST for routing. When TKEEP support is compiled in, it trims unused trailing subwords on the final beat of a packet. It sits between 64/128-bit DMA/switch fabric and 32-bit consumers, and supersedes the fixed 64-to-32 converter.

## Interface
- S_WIDTH, 64, slave data width; integer multiple of M_WIDTH.
- M_WIDTH, 32, master data width; multiple of 8.
- USER_WIDTH, 32, S_AXIS_TUSER / SRCDEST width.
- MSW_FIRST, 0, lane order: 0 emits bits [M_WIDTH-1:0] first; 1 emits the most-significant subword first.
- Derived: RATIO = S_WIDTH/M_WIDTH, a power of 2 ≥ 2. IW = clog2(RATIO).
- AXIS_ACLK  in  1  clock; all logic is rising-edge.
- AXIS_ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TVALID  in  1  slave valid.
- S_AXIS_TREADY  out  1  slave ready.
- S_AXIS_TDATA  in  S_WIDTH  slave data.
- S_AXIS_TKEEP  in  S_WIDTH/8  byte enables; present only with AXIS_DOWNSIZER_TKEEP_EN.
- S_AXIS_TLAST  in  1  end of packet.
- S_AXIS_TUSER  in  USER_WIDTH  sideband; sampled on the first beat of each packet.
- M_AXIS_TVALID  out  1  master valid.
- M_AXIS_TREADY  in  1  master ready.
- M_AXIS_TDATA  out  M_WIDTH  master data.
- M_AXIS_TKEEP  out  M_WIDTH/8  byte enables; present only with the macro.
- M_AXIS_TLAST  out  1  end of packet.
- SRCDEST  out  USER_WIDTH  TUSER of the current or most recent packet.

## Operation
- Storage:
  - Holding register with buf_data, buf_keep, buf_last, buf_valid.
  - Subword index idx[IW-1:0].
  - Last index lidx[IW-1:0].
  - first flag.
- Handshakes: s_xfr = S_AXIS_TVALID & S_AXIS_TREADY; m_xfr = M_AXIS_TVALID & M_AXIS_TREADY.
- State EMPTY (buf_valid = 0):
  - S_AXIS_TREADY = 1.
  - On s_xfr: load the buffer, set idx = 0, go to FULL.
- State FULL (buf_valid = 1):
  - M_AXIS_TVALID = 1.
  - M_AXIS_TDATA and M_AXIS_TKEEP come from subword idx (mapped through MSW_FIRST).
  - M_AXIS_TLAST = buf_last & (idx == lidx).
- In FULL, on m_xfr with idx != lidx: idx increments by 1.
- In FULL, on m_xfr with idx == lidx:
  - S_AXIS_TREADY = M_AXIS_TREADY, combinationally, so a new beat can load in the same cycle.
  - If s_xfr: reload the buffer, idx = 0, stay FULL.
  - Otherwise: go to EMPTY.
- Outputs are driven only from registers, except S_AXIS_TREADY in the last-subword case above.
- lidx without the macro: always RATIO-1.
- lidx with the macro, non-last beat: RATIO-1, and all subwords are emitted with keep passed through unchanged.
- lidx with the macro, TLAST beat: the index of the highest subword with any keep bit set.
- lidx with the macro, TLAST beat with all-zero keep: lidx = 0, and a single null subword is emitted with keep 0 and TLAST = 1.
- SRCDEST / first flag:
  - first = 1 after reset.
  - On an s_xfr with first = 1, SRCDEST <= S_AXIS_TUSER.
  - first <= S_AXIS_TLAST on every s_xfr.
  - SRCDEST holds its value between packets.
- Reset values: M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TDATA = 0, M_AXIS_TKEEP = 0, SRCDEST = 0, S_AXIS_TREADY = 1 (EMPTY), idx = 0, first = 1.
- Reset mid-packet: any held beat is discarded and M_AXIS_TVALID drops asynchronously. No partial-packet recovery is performed.

## Timing
- Latency: the first subword is valid on the cycle after s_xfr.
- Sustained throughput: exactly one master beat per cycle while M_AXIS_TREADY = 1, including across beat and packet boundaries.
- A slave beat therefore occupies lidx+1 master cycles.
- Back-pressure: when M_AXIS_TREADY = 0, all master outputs hold stable and S_AXIS_TREADY = 0 while in FULL.
- S_AXIS_TREADY does not depend on S_AXIS_TVALID.

## Configuration
- AXIS_DOWNSIZER_TKEEP_EN defined:
  - TKEEP ports exist.
  - Trailing empty subwords on TLAST beats are skipped.
  - Keep is forwarded per subword.
- AXIS_DOWNSIZER_TKEEP_EN undefined:
  - No TKEEP ports.
  - Every slave beat produces exactly RATIO master beats.
  - TLAST is asserted on subword RATIO-1.

## Structure
- Package axis_downsizer_pkg holds:
  - The state enum (EMPTY, FULL).
  - A clog2 function.
  - A subword-select function parametrised by MSW_FIRST.
- Sub-module axis_downsizer_lastsel: a priority encoder that maps S_AXIS_TKEEP (grouped per subword) to lidx. It is instantiated only under the macro.

## Test plan
- Single beat, 64→32, TDATA = 0x1111_2222_3333_4444, TLAST = 1, ready held at 1 -> master beats 0x33334444 then 0x11112222, TLAST on the second beat, S_AXIS_TREADY rises on the same cycle as the second beat.
- Back-to-back 4-beat packet, S_WIDTH = 128, M_WIDTH = 32, ready held at 1 -> 16 consecutive master beats with no gap, TLAST only on beat 16.
- Random M_AXIS_TREADY at 50% duty -> output stream equals the scoreboard reference, and no master signal changes while valid is high and ready is low.
- With the macro: 64→32, last beat keep = 0x0F -> one master beat with keep 0xF and TLAST; last beat keep = 0x00 -> one beat with keep 0 and TLAST.
- Two packets with TUSER 0xA5A5_0001 then 0x5A5A_0002 -> SRCDEST changes only on the first-beat s_xfr of each packet; mid-packet TUSER changes are ignored.
- Assert AXIS_ARESETN low while holding a beat with idx = 1 -> M_AXIS_TVALID = 0 immediately; after release, the next packet converts correctly and SRCDEST = 0 until its first beat.
